keypad_digit_display: RTL
=========================

KEYPAD_DIGIT_DISPLAY -- requirements
Module: keypad_digit_display

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 1000000: cycles KeyCode must hold unchanged before acceptance (10 ms at 100 MHz); legal range 2 to 2^24-1.
REQ-002 The block SHALL have parameter REFRESH_CYCLES, default 100000: cycles each display digit stays lit (1 ms at 100 MHz); legal range 2 to 2^20-1.
REQ-003 clk  in  1  100 MHz system clock; all logic is on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 KeyCode  in  4  hex key code from the keypad column-scan decoder, same clock domain; the code holds its last value between presses.
REQ-006 Clear  in  1  synchronous, active-high request to erase entered digits.
REQ-007 DigitsOut  out  16  last four accepted codes; [3:0] is the newest.
REQ-008 DigitCount  out  3  number of valid digits, 0 to 4.
REQ-009 KeyStrobe  out  1  one-cycle pulse on the cycle after a digit is accepted.
REQ-010 an  out  4  seven-segment anodes, active-low; an[0] is the rightmost digit.
REQ-011 seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.

Function
REQ-012 Candidate tracking SHALL work as follows: if KeyCode differs from Cand, then Cand <= KeyCode and StabCnt <= 0; otherwise StabCnt increments and saturates at STABLE_CYCLES-1.
REQ-013 Acceptance SHALL occur on the cycle where StabCnt == STABLE_CYCLES-1 and Cand != LastKey: LastKey <= Cand, DigitsOut <= {DigitsOut[11:0], Cand}, DigitCount <= min(DigitCount+1, 4), KeyStrobe <= 1 on the next cycle.
REQ-014 A stable code equal to LastKey SHALL never be accepted; the same key pressed twice in a row yields one digit (decoder limitation, by design).
REQ-015 Acceptance SHALL fire at most once per stable period, because LastKey == Cand after it fires.
REQ-016 A KeyCode glitch shorter than STABLE_CYCLES SHALL restart the count and produce no acceptance.
REQ-017 At DigitCount == 4, acceptance SHALL still shift: the oldest nibble DigitsOut[15:12] is discarded and DigitCount stays 4.
REQ-018 Clear SHALL set DigitsOut = 0 and DigitCount = 0 on the next edge, leaving LastKey, Cand and StabCnt unchanged.
REQ-019 When Clear and acceptance occur in the same cycle, Clear SHALL win: DigitsOut = 0, DigitCount = 0, KeyStrobe = 0, and LastKey still updates.
REQ-020 RefCnt SHALL count 0 to REFRESH_CYCLES-1 and wrap; on each wrap, the 2-bit Idx increments (3 wraps to 0).
REQ-021 Idx = i SHALL select nibble DigitsOut[4i+3:4i]; an = ~(1 << i) when i < DigitCount, else an = 4'b1111 and seg = 7'b1111111 (blanked).
REQ-022 seg SHALL use this hex encoding, active-low gfedcba:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, B = 0000011
  - C = 1000110, D = 0100001, E = 0000110, F = 0001110
REQ-023 an and seg SHALL be registered, changing one cycle after Idx or the data change; they SHALL never show two anodes low at once.

Reset
REQ-024 rst SHALL take priority over Clear and acceptance.
REQ-025 On rst: DigitsOut = 0, DigitCount = 0, KeyStrobe = 0, LastKey = 0, Cand = 0, StabCnt = 0, RefCnt = 0, Idx = 0, an = 4'b1111, seg = 7'b1111111.
REQ-026 Because LastKey resets to 0, code 0 held from reset SHALL NOT be accepted until some other key has been accepted first.
REQ-027 rst asserted mid-count SHALL discard any pending acceptance.

Verification (STABLE_CYCLES = 4, REFRESH_CYCLES = 8)
REQ-028 Glitch rejection: after reset, KeyCode = 5 for 3 cycles then 0 -> no KeyStrobe, DigitsOut = 0x0000, an = 1111.
REQ-029 Entry and shift: hold 1, 2, 3, 4, 5 for 10 cycles each -> five KeyStrobe pulses; DigitsOut = 0x2345; DigitCount = 4.
REQ-030 Repeat suppression: after 0x0001 is entered, hold 1 for 50 more cycles -> no further strobe.
REQ-031 Clear collision: assert Clear on the exact acceptance cycle of key 7 -> DigitsOut = 0, KeyStrobe = 0; holding 7 afterwards yields no entry.
REQ-032 Display scan: with DigitsOut = 0x00A8 and DigitCount = 2 -> an cycles 1110 (seg 0000000), then 1101 (seg 0001000), then 1111 and 1111, each for 8 cycles, repeating.
REQ-033 Reset mid-operation: rst during a display scan with DigitCount = 3 -> all outputs hold their REQ-025 values the cycle after rst.

Source files
------------

// File: rtl/keypad_digit_display.sv
// Debounced hex keypad entry into a four-digit shift register, with a
// time-multiplexed active-low seven-segment display of the valid digits.
module keypad_digit_display #(
    parameter int unsigned STABLE_CYCLES  = 1000000,
    parameter int unsigned REFRESH_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  KeyCode,
    input  logic        Clear,
    output logic [15:0] DigitsOut,
    output logic [2:0]  DigitCount,
    output logic        KeyStrobe,
    output logic [3:0]  an,
    output logic [6:0]  seg
);
    localparam logic [23:0] STAB_LAST = 24'(STABLE_CYCLES - 1);
    localparam logic [19:0] REF_LAST  = 20'(REFRESH_CYCLES - 1);

    logic [3:0]  cand;
    logic [3:0]  last_key;
    logic [23:0] stab_cnt;
    logic [19:0] ref_cnt;
    logic [1:0]  idx;
    logic        accept;
    logic [3:0]  nibble;
    logic        digit_lit;
    logic [6:0]  seg_code;

    // Comparing against last_key makes acceptance fire once per stable period.
    assign accept = (stab_cnt == STAB_LAST) && (cand != last_key);

    always_ff @(posedge clk) begin
        if (rst) begin
            cand     <= 4'd0;
            stab_cnt <= 24'd0;
        end else if (KeyCode != cand) begin
            cand     <= KeyCode;
            stab_cnt <= 24'd0;
        end else if (stab_cnt != STAB_LAST) begin
            stab_cnt <= stab_cnt + 24'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_key   <= 4'd0;
            DigitsOut  <= 16'd0;
            DigitCount <= 3'd0;
            KeyStrobe  <= 1'b0;
        end else begin
            KeyStrobe <= accept && !Clear;
            if (accept)
                last_key <= cand;
            // Clear beats a same-cycle acceptance, but last_key still updates.
            if (Clear) begin
                DigitsOut  <= 16'd0;
                DigitCount <= 3'd0;
            end else if (accept) begin
                DigitsOut <= {DigitsOut[11:0], cand};
                if (DigitCount != 3'd4)
                    DigitCount <= DigitCount + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt <= 20'd0;
            idx     <= 2'd0;
        end else if (ref_cnt == REF_LAST) begin
            ref_cnt <= 20'd0;
            idx     <= idx + 2'd1;
        end else begin
            ref_cnt <= ref_cnt + 20'd1;
        end
    end

    always_comb begin
        nibble = 4'd0;
        case (idx)
            2'd0: nibble = DigitsOut[3:0];
            2'd1: nibble = DigitsOut[7:4];
            2'd2: nibble = DigitsOut[11:8];
            2'd3: nibble = DigitsOut[15:12];
            default: nibble = 4'd0;
        endcase
    end

    assign digit_lit = ({1'b0, idx} < DigitCount);

    always_comb begin
        seg_code = 7'b1111111;
        case (nibble)
            4'h0: seg_code = 7'b1000000;
            4'h1: seg_code = 7'b1111001;
            4'h2: seg_code = 7'b0100100;
            4'h3: seg_code = 7'b0110000;
            4'h4: seg_code = 7'b0011001;
            4'h5: seg_code = 7'b0010010;
            4'h6: seg_code = 7'b0000010;
            4'h7: seg_code = 7'b1111000;
            4'h8: seg_code = 7'b0000000;
            4'h9: seg_code = 7'b0010000;
            4'hA: seg_code = 7'b0001000;
            4'hB: seg_code = 7'b0000011;
            4'hC: seg_code = 7'b1000110;
            4'hD: seg_code = 7'b0100001;
            4'hE: seg_code = 7'b0000110;
            4'hF: seg_code = 7'b0001110;
            default: seg_code = 7'b1111111;
        endcase
    end

    // Registered drive: exactly one anode low, or all dark for unused positions.
    always_ff @(posedge clk) begin
        if (rst || !digit_lit) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= seg_code;
        end
    end
endmodule
